// File: rtl/sm_dot_pkg.sv
// Shared types and sizing helpers for the sm_dot_accum multi-lane MAC engine.
package sm_dot_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Default sizing for the standard 32-bit, 4-lane build
    localparam int unsigned DEF_NBITS      = 32;
    localparam int unsigned DEF_LANES      = 4;
    localparam int unsigned DEF_PROD_NBITS = 2 * DEF_NBITS;
    localparam int unsigned DEF_TREE_DEPTH = $clog2(DEF_LANES);

    // Full-precision width of one signed lane product
    function automatic int unsigned prod_nbits(input int unsigned nbits);
        return 2 * nbits;
    endfunction

    // Number of pairwise adder levels needed to reduce all lanes to one sum
    function automatic int unsigned tree_depth(input int unsigned lanes);
        return $clog2(lanes);
    endfunction

endpackage

// File: rtl/sm_dot_accum_lane_mul.sv
// One signed lane multiplier with its stage-1 product register.
module sm_DotLaneMul
    import sm_dot_pkg::*;
#(
    parameter int unsigned p_nbits = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_en,
    input  logic [p_nbits-1:0]             i_a,
    input  logic [p_nbits-1:0]             i_b,
    output logic [prod_nbits(p_nbits)-1:0] o_prod
);

    localparam int unsigned PW = prod_nbits(p_nbits);

    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    logic signed [PW-1:0] r_prod;

    // Sign-extend first so a PW-bit multiply yields the exact signed product
    assign w_a_ext = PW'($signed(i_a));
    assign w_b_ext = PW'($signed(i_b));

    // Capture the product on an accepted operand beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod <= '0;
        end else if (i_en) begin
            r_prod <= w_a_ext * w_b_ext;
        end
    end

    assign o_prod = r_prod;

endmodule

// File: rtl/vc_regs.sv
// Generic register with synchronous active-high reset and load enable.
module vc_EnResetReg #(
    parameter int unsigned           p_nbits       = 1,
    parameter logic [p_nbits-1:0]    p_reset_value = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_en,
    input  logic [p_nbits-1:0] i_d,
    output logic [p_nbits-1:0] o_q
);

    logic [p_nbits-1:0] r_q;

    // Load on enable, return to the reset value on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= p_reset_value;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sm_dot_accum.sv
// Multi-lane signed dot-product accumulator: one job = cfg, N operand beats, one result.
// Build option: define SM_DOT_ACCUM_RELU_EN to clamp negative results to zero at the
// output (the accumulator itself is never clamped).
module sm_dot_accum
    import sm_dot_pkg::*;
#(
    parameter int unsigned p_nbits     = 32,
    parameter int unsigned p_lanes     = 4,
    parameter int unsigned p_len_nbits = 16,
    parameter int unsigned p_acc_nbits = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_val,
    output logic                         cfg_rdy,
    input  logic [p_len_nbits-1:0]       cfg_len,
    input  logic                         in_val,
    output logic                         in_rdy,
    input  logic [p_lanes*p_nbits-1:0]   in_a,
    input  logic [p_lanes*p_nbits-1:0]   in_b,
    output logic                         out_val,
    input  logic                         out_rdy,
    output logic [p_acc_nbits-1:0]       out_data,
    output logic                         busy
);

    localparam int unsigned NW    = p_nbits;
    localparam int unsigned LN    = p_lanes;
    localparam int unsigned LW    = p_len_nbits;
    localparam int unsigned AW    = p_acc_nbits;
    localparam int unsigned PW    = prod_nbits(p_nbits);
    localparam int unsigned DEPTH = tree_depth(p_lanes);

    state_t          r_state;
    logic            r_cfg_rdy;
    logic            r_in_rdy;
    logic            r_out_val;
    logic            r_busy;
    logic            r_s1_val;
    logic [AW-1:0]   r_out_data;

    logic            w_cfg_fire;
    logic            w_in_fire;
    logic            w_out_fire;
    logic [LW-1:0]   w_cnt;
    logic [LW-1:0]   w_cnt_d;
    logic            w_cnt_en;
    logic [AW-1:0]   w_acc;
    logic [AW-1:0]   w_acc_d;
    logic            w_acc_en;
    logic [AW-1:0]   w_acc_next;
    logic [AW-1:0]   w_sum;
    logic [AW-1:0]   w_out_next;
    logic [PW-1:0]   w_prod [LN];
    logic [AW-1:0]   w_tree [DEPTH+1][LN];

    assign w_cfg_fire = cfg_val && r_cfg_rdy;
    assign w_in_fire  = in_val  && r_in_rdy;
    assign w_out_fire = r_out_val && out_rdy;

    // Stage 1: one registered multiplier per lane
    for (genvar g = 0; g < LN; g++) begin : g_lane
        sm_DotLaneMul #(.p_nbits(NW)) u_mul (
            .clk    (clk),
            .reset  (reset),
            .i_en   (w_in_fire),
            .i_a    (in_a[g*NW +: NW]),
            .i_b    (in_b[g*NW +: NW]),
            .o_prod (w_prod[g])
        );
    end

    // Stage 2: sign-extend products and reduce them pairwise to a single sum
    always_comb begin
        for (int unsigned k = 0; k <= DEPTH; k++) begin
            for (int unsigned i = 0; i < LN; i++) begin
                w_tree[k][i] = '0;
            end
        end
        for (int unsigned i = 0; i < LN; i++) begin
            w_tree[0][i] = AW'($signed(w_prod[i]));
        end
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            for (int unsigned i = 0; i < (LN >> k); i++) begin
                w_tree[k][i] = w_tree[k-1][2*i] + w_tree[k-1][2*i+1];
            end
        end
    end

    assign w_sum      = w_tree[DEPTH][0];
    assign w_acc_next = w_acc + (r_s1_val ? w_sum : '0);

    // Accumulator: cleared at job start, summed whenever a stage-1 beat is present
    assign w_acc_en = w_cfg_fire || r_s1_val;
    assign w_acc_d  = w_cfg_fire ? '0 : w_acc_next;

    vc_EnResetReg #(.p_nbits(AW), .p_reset_value('0)) u_acc_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_acc_en),
        .i_d   (w_acc_d),
        .o_q   (w_acc)
    );

    // Remaining-beat counter: loaded at job start, decremented per accepted beat
    assign w_cnt_en = w_cfg_fire || w_in_fire;
    assign w_cnt_d  = w_cfg_fire ? cfg_len : (w_cnt - LW'(1));

    vc_EnResetReg #(.p_nbits(LW), .p_reset_value('0)) u_cnt_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_cnt_en),
        .i_d   (w_cnt_d),
        .o_q   (w_cnt)
    );

`ifdef SM_DOT_ACCUM_RELU_EN
    assign w_out_next = w_acc_next[AW-1] ? '0 : w_acc_next;
`else
    assign w_out_next = w_acc_next;
`endif

    // Control FSM with registered handshake outputs and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cfg_rdy  <= 1'b1;
            r_in_rdy   <= 1'b0;
            r_out_val  <= 1'b0;
            r_out_data <= '0;
            r_busy     <= 1'b0;
            r_s1_val   <= 1'b0;
        end else begin
            r_s1_val <= w_in_fire;
            case (r_state)
                ST_IDLE: begin
                    if (w_cfg_fire) begin
                        r_cfg_rdy <= 1'b0;
                        r_busy    <= 1'b1;
                        if (cfg_len == '0) begin
                            r_state    <= ST_DONE;
                            r_out_val  <= 1'b1;
                            r_out_data <= '0;
                        end else begin
                            r_state  <= ST_ACC;
                            r_in_rdy <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (w_in_fire && (w_cnt == LW'(1))) begin
                        r_state  <= ST_DRAIN;
                        r_in_rdy <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // The last product sums into acc on this edge; publish the same value
                    r_state    <= ST_DONE;
                    r_out_val  <= 1'b1;
                    r_out_data <= w_out_next;
                end
                ST_DONE: begin
                    if (w_out_fire) begin
                        r_state   <= ST_IDLE;
                        r_out_val <= 1'b0;
                        r_cfg_rdy <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cfg_rdy <= 1'b1;
                    r_in_rdy  <= 1'b0;
                    r_out_val <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_rdy  = r_cfg_rdy;
    assign in_rdy   = r_in_rdy;
    assign out_val  = r_out_val;
    assign out_data = r_out_data;
    assign busy     = r_busy;

endmodule
